sprite_compositor: RTL and testbench



---
 rtl/sprite_pkg.sv | 15 +
 rtl/layer_prio_enc.sv | 21 ++
 rtl/sprite_compositor.sv | 132 +++++++++++++
 tb/tb_sprite_compositor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants and pair-index helpers for the sprite compositor.
package sprite_pkg;

   localparam int COLR_BITS_DFLT = 12;

   function automatic int n_pairs(input int n);
      return (n * (n - 1)) / 2;
   endfunction

   // Pairs (i,j), i<j, flattened in lexicographic order.
   function automatic int pair_index(input int i, input int j, input int n);
      return (i * n) - ((i * (i + 1)) / 2) + (j - i - 1);
   endfunction

endpackage

// File: rtl/layer_prio_enc.sv
// Fixed-priority encoder: lowest set bit of i_act wins.
module layer_prio_enc #(
   parameter int N = 4
) (
   input  logic [N-1:0]         i_act,
   output logic [$clog2(N)-1:0] o_idx,
   output logic                 o_any
);

   localparam int IW = $clog2(N);

   always_comb begin
      o_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (i_act[k]) o_idx = IW'(k);
      end
   end

   assign o_any = |i_act;

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage priority merge of sprite layers over a background, with matched
// sync delay and per-frame sprite-pair collision flags.
module sprite_compositor
   import sprite_pkg::*;
#(
   parameter  int N_LAYERS  = 4,
   parameter  int COLR_BITS = COLR_BITS_DFLT,
   localparam int N_PAIRS   = n_pairs(N_LAYERS)
) (
   input  logic                          clk_pix,
   input  logic                          rst_n,
   input  logic                          frame,
   input  logic                          de,
   input  logic                          hsync,
   input  logic                          vsync,
   input  logic [N_LAYERS-1:0]           layer_en,
   input  logic [N_LAYERS*COLR_BITS-1:0] layer_pix,
   input  logic [N_LAYERS-1:0]           layer_drawing,
   input  logic [COLR_BITS-1:0]          bg_colr,
   output logic [COLR_BITS-1:0]          pix_out,
   output logic                          de_out,
   output logic                          hsync_out,
   output logic                          vsync_out,
   output logic [N_PAIRS-1:0]            coll_status,
   output logic                          coll_valid
);

   localparam int IW = $clog2(N_LAYERS);

   logic [N_LAYERS-1:0]  w_act;
   logic [IW-1:0]        w_idx;
   logic                 w_any;
   logic [COLR_BITS-1:0] w_sel_colr;
   logic [N_PAIRS-1:0]   w_hit;
   logic [COLR_BITS-1:0] w_pix_d;

   logic [COLR_BITS-1:0] r_colr_s1;
   logic [COLR_BITS-1:0] r_bg_s1;
   logic                 r_any_s1;
   logic                 r_de_s1;
   logic                 r_hs_s1;
   logic                 r_vs_s1;
   logic [COLR_BITS-1:0] r_pix;
   logic                 r_de_s2;
   logic                 r_hs_s2;
   logic                 r_vs_s2;
   logic [N_PAIRS-1:0]   r_accum;
   logic [N_PAIRS-1:0]   r_coll_status;
   logic                 r_coll_valid;

   assign w_act = layer_drawing & layer_en;

   layer_prio_enc #(
      .N (N_LAYERS)
   ) u_prio (
      .i_act (w_act),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   always_comb begin
      w_sel_colr = '0;
      for (int k = 0; k < N_LAYERS; k++) begin
         if (w_idx == IW'(k)) w_sel_colr = layer_pix[k*COLR_BITS +: COLR_BITS];
      end
   end

   // Collisions are taken from the input side and only inside the active area.
   always_comb begin
      w_hit = '0;
      for (int i = 0; i < N_LAYERS - 1; i++) begin
         for (int j = i + 1; j < N_LAYERS; j++) begin
            w_hit[pair_index(i, j, N_LAYERS)] = de & w_act[i] & w_act[j];
         end
      end
   end

   always_comb begin
      w_pix_d = '0;
      if (r_de_s1) w_pix_d = r_any_s1 ? r_colr_s1 : r_bg_s1;
   end

   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         r_colr_s1 <= '0;
         r_bg_s1   <= '0;
         r_any_s1  <= 1'b0;
         r_de_s1   <= 1'b0;
         r_hs_s1   <= 1'b0;
         r_vs_s1   <= 1'b0;
         r_pix     <= '0;
         r_de_s2   <= 1'b0;
         r_hs_s2   <= 1'b0;
         r_vs_s2   <= 1'b0;
      end else begin
         r_colr_s1 <= w_sel_colr;
         r_bg_s1   <= bg_colr;
         r_any_s1  <= w_any;
         r_de_s1   <= de;
         r_hs_s1   <= hsync;
         r_vs_s1   <= vsync;
         r_pix     <= w_pix_d;
         r_de_s2   <= r_de_s1;
         r_hs_s2   <= r_hs_s1;
         r_vs_s2   <= r_vs_s1;
      end
   end

   // A hit sampled together with frame still lands in the published status.
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         r_accum       <= '0;
         r_coll_status <= '0;
         r_coll_valid  <= 1'b0;
      end else if (frame) begin
         r_coll_status <= r_accum | w_hit;
         r_accum       <= '0;
         r_coll_valid  <= 1'b1;
      end else begin
         r_accum       <= r_accum | w_hit;
         r_coll_valid  <= 1'b0;
      end
   end

   assign pix_out     = r_pix;
   assign de_out      = r_de_s2;
   assign hsync_out   = r_hs_s2;
   assign vsync_out   = r_vs_s2;
   assign coll_status = r_coll_status;
   assign coll_valid  = r_coll_valid;

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: directed vectors, queued expectations.
module tb_sprite_compositor;

   localparam int N = 4;
   localparam int C = 12;
   localparam int P = 6;

   typedef struct packed {
      logic [C-1:0] pix;
      logic         de;
      logic         hs;
      logic         vs;
   } exp_t;

   logic           clk_pix = 1'b0;
   logic           rst_n;
   logic           frame;
   logic           de;
   logic           hsync;
   logic           vsync;
   logic [N-1:0]   layer_en;
   logic [N*C-1:0] layer_pix;
   logic [N-1:0]   layer_drawing;
   logic [C-1:0]   bg_colr;
   logic [C-1:0]   pix_out;
   logic           de_out;
   logic           hsync_out;
   logic           vsync_out;
   logic [P-1:0]   coll_status;
   logic           coll_valid;

   exp_t         pix_q[$];
   logic [P-1:0] coll_q[$];
   int           n_cmp = 0;
   int           n_err = 0;

   // Layer colours: l3=0AA, l2=0F0, l1=F00, l0=123
   localparam logic [N*C-1:0] PIX   = {12'h0AA, 12'h0F0, 12'hF00, 12'h123};
   localparam logic [N*C-1:0] PIX_Z = {12'h0AA, 12'h0F0, 12'hF00, 12'h000};
   localparam logic [N*C-1:0] PIX_W = {12'h0AA, 12'h0F0, 12'hF00, 12'hFFF};

   sprite_compositor #(
      .N_LAYERS  (N),
      .COLR_BITS (C)
   ) dut (
      .clk_pix       (clk_pix),
      .rst_n         (rst_n),
      .frame         (frame),
      .de            (de),
      .hsync         (hsync),
      .vsync         (vsync),
      .layer_en      (layer_en),
      .layer_pix     (layer_pix),
      .layer_drawing (layer_drawing),
      .bg_colr       (bg_colr),
      .pix_out       (pix_out),
      .de_out        (de_out),
      .hsync_out     (hsync_out),
      .vsync_out     (vsync_out),
      .coll_status   (coll_status),
      .coll_valid    (coll_valid)
   );

   always #5 clk_pix = ~clk_pix;

   task automatic chk(input string nm, input logic [C-1:0] got, input logic [C-1:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", nm, got, want);
      end
   endtask

   // Drive one cycle at a negedge; expected output due two cycles later.
   task automatic drv(input logic [N-1:0] en, input logic [N-1:0] drw,
                      input logic [N*C-1:0] pix, input logic [C-1:0] bg,
                      input logic d, input logic hs, input logic vs, input logic fr,
                      input logic [C-1:0] exp_pix, input logic [P-1:0] exp_coll);
      exp_t e;
      layer_en      = en;
      layer_drawing = drw;
      layer_pix     = pix;
      bg_colr       = bg;
      de            = d;
      hsync         = hs;
      vsync         = vs;
      frame         = fr;
      if (rst_n) e = '{pix: exp_pix, de: d, hs: hs, vs: vs};
      else       e = '0;
      pix_q.push_back(e);
      if (fr) coll_q.push_back(exp_coll);
      @(negedge clk_pix);
   endtask

   task automatic idle();
      drv(4'hF, 4'h0, PIX, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, '0);
   endtask

   task automatic frm(input logic [P-1:0] exp_coll);
      drv(4'hF, 4'h0, PIX, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, exp_coll);
   endtask

   // Monitor: pixel stream every cycle, collision status on each coll_valid.
   initial begin
      exp_t         e;
      logic [P-1:0] ec;
      forever begin
         @(posedge clk_pix);
         #2;
         if (pix_q.size() >= 2) begin
            e = pix_q.pop_front();
            n_cmp++;
            if ({pix_out, de_out, hsync_out, vsync_out} !== e) begin
               n_err++;
               $display("FAIL pixel @%0t: got pix=%h de=%b hs=%b vs=%b, want pix=%h de=%b hs=%b vs=%b",
                        $time, pix_out, de_out, hsync_out, vsync_out, e.pix, e.de, e.hs, e.vs);
            end
         end
         if (coll_valid === 1'b1) begin
            n_cmp++;
            if (coll_q.size() == 0) begin
               n_err++;
               $display("FAIL coll_valid @%0t: got unexpected pulse, want none", $time);
            end else begin
               ec = coll_q.pop_front();
               if (coll_status !== ec) begin
                  n_err++;
                  $display("FAIL coll_status @%0t: got %b, want %b", $time, coll_status, ec);
               end
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      frame = 1'b0; de = 1'b0; hsync = 1'b0; vsync = 1'b0;
      layer_en = 4'hF; layer_pix = PIX; layer_drawing = '0; bg_colr = '0;
      #1;
      chk("reset pix_out", pix_out, '0);
      chk("reset de_out", {11'b0, de_out}, '0);
      chk("reset hsync_out", {11'b0, hsync_out}, '0);
      chk("reset vsync_out", {11'b0, vsync_out}, '0);
      chk("reset coll_status", {6'b0, coll_status}, '0);
      chk("reset coll_valid", {11'b0, coll_valid}, '0);
      @(negedge clk_pix);

      // Reset release and pipeline latency
      repeat (3) drv(4'hF, 4'h0, PIX, 12'h00F, 1'b1, 1'b0, 1'b0, 1'b0, 12'h00F, '0);
      rst_n = 1'b1;
      repeat (3) drv(4'hF, 4'h0, PIX, 12'h00F, 1'b1, 1'b0, 1'b0, 1'b0, 12'h00F, '0);

      // Priority and masking
      drv(4'hF, 4'b0110, PIX,   12'h00F, 1'b1, 1'b0, 1'b0, 1'b0, 12'hF00, '0);
      drv(4'hF, 4'b0111, PIX,   12'h00F, 1'b1, 1'b0, 1'b0, 1'b0, 12'h123, '0);
      drv(4'b1110, 4'b0111, PIX, 12'h00F, 1'b1, 1'b0, 1'b0, 1'b0, 12'hF00, '0);
      drv(4'hF, 4'b0001, PIX_Z, 12'hABC, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, '0);
      drv(4'hF, 4'b0000, PIX,   12'hABC, 1'b1, 1'b0, 1'b0, 1'b0, 12'hABC, '0);

      // Blanking with sync patterns
      drv(4'hF, 4'b0001, PIX_W, 12'hABC, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, '0);
      drv(4'hF, 4'b0001, PIX_W, 12'hABC, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, '0);
      drv(4'hF, 4'b0001, PIX_W, 12'hABC, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, '0);
      drv(4'hF, 4'b0001, PIX_W, 12'hABC, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, '0);

      // Priority section hit pairs (0,1),(0,2),(1,2); back-to-back frame is empty
      frm(6'b001011);
      frm(6'b000000);
      idle();

      // Layers 1 and 3 overlap for 5 pixels
      repeat (5) drv(4'hF, 4'b1010, PIX, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 12'hF00, '0);
      idle();
      frm(6'b010000);
      repeat (2) drv(4'hF, 4'b0010, PIX, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 12'hF00, '0);
      frm(6'b000000);

      // Exclusions: overlap in blanking, overlap with a masked layer
      repeat (2) drv(4'hF, 4'b1010, PIX, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, '0);
      repeat (2) drv(4'b0111, 4'b1010, PIX, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 12'hF00, '0);
      frm(6'b000000);
      idle();

      // Hit in the same cycle as frame is published
      drv(4'hF, 4'b0011, PIX, 12'h000, 1'b1, 1'b0, 1'b0, 1'b1, 12'h123, 6'b000001);
      idle();

      // Asynchronous reset with a non-empty accumulator
      repeat (3) drv(4'hF, 4'b1010, PIX, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 12'hF00, '0);
      @(posedge clk_pix);
      #3;
      rst_n = 1'b0;
      pix_q.delete();
      #1;
      chk("async reset pix_out", pix_out, '0);
      chk("async reset syncs", {9'b0, de_out, hsync_out, vsync_out}, '0);
      chk("async reset coll_status", {6'b0, coll_status}, '0);
      @(negedge clk_pix);
      repeat (2) drv(4'hF, 4'b1010, PIX, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, '0);
      rst_n = 1'b1;
      repeat (2) drv(4'hF, 4'h0, PIX, 12'h00F, 1'b1, 1'b0, 1'b0, 1'b0, 12'h00F, '0);
      frm(6'b000000);
      repeat (4) idle();

      n_cmp++;
      if (coll_q.size() != 0) begin
         n_err++;
         $display("FAIL coll_valid count: got %0d pending, want 0", coll_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
